rob_recovery_ctrl: RTL and testbench
====================================

# rob_recovery_ctrl

Branch-misprediction recovery sequencer for the reorder buffer. It watches the three completion ports (ALU1, ALU2, LSU) and keeps the oldest outstanding mispredicted ROB entry. When that entry reaches retirement, it sequences the machine-wide flush, the PC redirect and a fixed drain window. It sits between the execution units, the ROB retire ports and the fetch/rename front end, and is the only driver of the ROB `Flush` input.

## Interface
Parameters:
- `ROB_INDEX_SIZE`, 7: ROB index width; ROB depth is 2^ROB_INDEX_SIZE.
- `DRAIN_CYCLES`, 3: cycles `Recovery_Stall` stays high after the flush pulse; legal range 1–15.

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `ALU1_valid`, `ALU1_mispred`  in  1 each  completion strobe; misprediction flag.
- `ALU1_index`  in  ROB_INDEX_SIZE  ROB entry of the completion.
- `ALU1_new_PC`  in  16  correct target.
- `ALU2_*`, `LSU_*`  in  same widths and meaning as `ALU1_*`.
- `ROB_Retire_Ptr`  in  ROB_INDEX_SIZE  current ROB retire pointer.
- `ROB_Retire1_V`, `ROB_Retire2_V`  in  1 each  retire slot valid.
- `ROB_Retire1_Index`, `ROB_Retire2_Index`  in  ROB_INDEX_SIZE  entries retiring this cycle.
- `Flush`  out  1  one-cycle flush pulse to ROB, reservation stations and store buffer.
- `Redirect_V`  out  1  PC redirect strobe; coincident with `Flush`.
- `Redirect_PC`  out  16  redirect target.
- `Recovery_Stall`  out  1  holds dispatch during flush and drain.
- `Squash_Retire2`  out  1  combinational; blocks retire slot 2 when slot 1 is the mispredict.
- `Pending_V`  out  1  a mispredict is being tracked.
- `Pending_Index`  out  ROB_INDEX_SIZE  ROB index of the tracked mispredict.

## Operation
- States: IDLE, PENDING, FLUSH, DRAIN. Encoded as 2 bits.
- Age of an index = (index − `ROB_Retire_Ptr`) mod 2^ROB_INDEX_SIZE, unsigned ROB_INDEX_SIZE bits. A smaller age is older.
- Candidate events: each port with `valid && mispred`. Among simultaneous candidates the oldest wins. On an equal index, priority is ALU1 > ALU2 > LSU.
- **IDLE**: on any candidate, capture its index and PC into the pending registers and go to PENDING.
- **PENDING**:
  - A new candidate replaces the pending entry only if it is strictly older.
  - On `ROB_Retire1_V && ROB_Retire1_Index == Pending_Index`, or the same condition on retire slot 2, go to FLUSH.
  - A retire match has priority over a same-cycle candidate update.
- **FLUSH** (exactly one cycle):
  - `Flush = Redirect_V = 1`; `Redirect_PC` = pending PC.
  - Clear `Pending_V`.
  - Load the drain counter with `DRAIN_CYCLES`, then go to DRAIN.
- **DRAIN**: decrement the counter each cycle and return to IDLE when it reaches 1. All candidates arriving in FLUSH or DRAIN are wrong-path and are ignored.
- `Squash_Retire2` = (state == PENDING) && `ROB_Retire1_V` && (`ROB_Retire1_Index` == `Pending_Index`).
- `Recovery_Stall` = (state == FLUSH) || (state == DRAIN).
- Wrap-around: the age arithmetic is modulo the ROB depth. An index numerically below `ROB_Retire_Ptr` is younger than one above it.

## Timing
- Reset (`RST_N` low, asynchronous): state IDLE.
  - All outputs 0; `Redirect_PC`, `Pending_Index` and the counter are 0.
  - Reset asserted mid-FLUSH or mid-DRAIN aborts immediately; no redirect is emitted.
- Candidate → `Pending_V`/`Pending_Index` valid the next cycle (1-cycle latency).
- Retire match at edge N → `Flush`/`Redirect_V` high during cycle N+1 only.
- `Recovery_Stall` is high for 1 + `DRAIN_CYCLES` cycles starting at N+1.
- `Flush`, `Redirect_V`, `Redirect_PC` and `Pending_*` are registered. `Squash_Retire2` is same-cycle combinational.
- Back-to-back: a candidate in the first IDLE cycle after DRAIN is accepted normally.

## Structure
- Shared package `rob_pkg`:
  - `ROB_INDEX_SIZE`.
  - Recovery state enum constants (IDLE = 0, PENDING = 1, FLUSH = 2, DRAIN = 3).
  - Helper function `rob_age(index, retire_ptr)`.
- One sub-module, `mispred_age_select`: a combinational 3-way oldest-candidate picker. It outputs `sel_V`, `sel_index` and `sel_PC`, and is reused by the top FSM.

## Test plan
- **Single mispredict**: Retire_Ptr = 0; ALU1 mispred index 5, PC 0x1234; retire1 index 5 at cycle 10 → `Flush`/`Redirect_V` high in cycle 11 only, `Redirect_PC` = 0x1234, `Recovery_Stall` high cycles 11–14 (`DRAIN_CYCLES` = 3).
- **Oldest select with wrap**: Retire_Ptr = 120; ALU2 index 2 and LSU index 125 in the same cycle → `Pending_Index` = 125. A later ALU1 index 122 replaces it → `Pending_Index` = 122. A later index 126 is ignored.
- **Slot-2 squash**: pending index 40; retire1 = 40 and retire2 = 41 → `Squash_Retire2` = 1 in that cycle. Retire2 = 40 with retire1 = 39 → `Squash_Retire2` = 0, and `Flush` pulses the next cycle.
- **Wrong-path filter**: an LSU mispredict index 50 during DRAIN → no capture; `Pending_V` stays 0 after return to IDLE.
- **Reset mid-drain**: `RST_N` low in the second DRAIN cycle → all outputs 0 in the same cycle. After release, IDLE with no redirect.
- **Retire-vs-event race**: in PENDING (index 10), retire1 = 10 and ALU1 mispred index 12 in the same cycle → FLUSH with the index-10 PC; index 12 is not captured.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB recovery types: index width, recovery states, completion payload, age helper.
package rob_pkg;

    localparam int unsigned ROB_INDEX_SIZE = 7;
    localparam int unsigned PC_W           = 16;
    localparam int unsigned CNT_W          = 4;

    typedef logic [ROB_INDEX_SIZE-1:0] rob_idx_t;
    typedef logic [PC_W-1:0]           pc_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLUSH   = 2'd2,
        DRAIN   = 2'd3
    } rec_state_t;

    // One execution-unit completion as seen by the recovery logic.
    typedef struct packed {
        logic     valid;
        logic     mispred;
        rob_idx_t index;
        pc_t      new_pc;
    } cmpl_t;

    // Distance from the retire pointer; smaller means older. Wraps modulo ROB depth.
    function automatic rob_idx_t rob_age(input rob_idx_t index, input rob_idx_t retire_ptr);
        return index - retire_ptr;
    endfunction

endpackage

// File: rtl/rob_recovery_ctrl_if.sv
// Completion, retire and recovery signals between the ROB/execution side and the recovery controller.
interface rob_recovery_ctrl_if;
    import rob_pkg::*;

    logic     ALU1_valid;
    logic     ALU1_mispred;
    rob_idx_t ALU1_index;
    pc_t      ALU1_new_PC;

    logic     ALU2_valid;
    logic     ALU2_mispred;
    rob_idx_t ALU2_index;
    pc_t      ALU2_new_PC;

    logic     LSU_valid;
    logic     LSU_mispred;
    rob_idx_t LSU_index;
    pc_t      LSU_new_PC;

    rob_idx_t ROB_Retire_Ptr;
    logic     ROB_Retire1_V;
    logic     ROB_Retire2_V;
    rob_idx_t ROB_Retire1_Index;
    rob_idx_t ROB_Retire2_Index;

    logic     Flush;
    logic     Redirect_V;
    pc_t      Redirect_PC;
    logic     Recovery_Stall;
    logic     Squash_Retire2;
    logic     Pending_V;
    rob_idx_t Pending_Index;

    // Environment side: execution units, ROB retire ports, front end.
    modport master (
        output ALU1_valid, ALU1_mispred, ALU1_index, ALU1_new_PC,
        output ALU2_valid, ALU2_mispred, ALU2_index, ALU2_new_PC,
        output LSU_valid,  LSU_mispred,  LSU_index,  LSU_new_PC,
        output ROB_Retire_Ptr, ROB_Retire1_V, ROB_Retire2_V,
        output ROB_Retire1_Index, ROB_Retire2_Index,
        input  Flush, Redirect_V, Redirect_PC, Recovery_Stall,
        input  Squash_Retire2, Pending_V, Pending_Index
    );

    // Recovery controller side.
    modport slave (
        input  ALU1_valid, ALU1_mispred, ALU1_index, ALU1_new_PC,
        input  ALU2_valid, ALU2_mispred, ALU2_index, ALU2_new_PC,
        input  LSU_valid,  LSU_mispred,  LSU_index,  LSU_new_PC,
        input  ROB_Retire_Ptr, ROB_Retire1_V, ROB_Retire2_V,
        input  ROB_Retire1_Index, ROB_Retire2_Index,
        output Flush, Redirect_V, Redirect_PC, Recovery_Stall,
        output Squash_Retire2, Pending_V, Pending_Index
    );

endinterface

// File: rtl/mispred_age_select.sv
// Combinational picker: oldest mispredicting completion among ALU1, ALU2, LSU.
module mispred_age_select
    import rob_pkg::*;
(
    input  cmpl_t    alu1,
    input  cmpl_t    alu2,
    input  cmpl_t    lsu,
    input  rob_idx_t retire_ptr,
    output logic     sel_V,
    output rob_idx_t sel_index,
    output pc_t      sel_PC
);

    // Strict-less replacement keeps the earlier port on equal age: ALU1 > ALU2 > LSU.
    always_comb begin
        sel_V     = 1'b0;
        sel_index = '0;
        sel_PC    = '0;
        if (alu1.valid && alu1.mispred) begin
            sel_V     = 1'b1;
            sel_index = alu1.index;
            sel_PC    = alu1.new_pc;
        end
        if (alu2.valid && alu2.mispred &&
            (!sel_V || (rob_age(alu2.index, retire_ptr) < rob_age(sel_index, retire_ptr)))) begin
            sel_V     = 1'b1;
            sel_index = alu2.index;
            sel_PC    = alu2.new_pc;
        end
        if (lsu.valid && lsu.mispred &&
            (!sel_V || (rob_age(lsu.index, retire_ptr) < rob_age(sel_index, retire_ptr)))) begin
            sel_V     = 1'b1;
            sel_index = lsu.index;
            sel_PC    = lsu.new_pc;
        end
    end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Branch-misprediction recovery sequencer: track oldest mispredict, flush and redirect at its retirement, then drain.
module rob_recovery_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3   // legal range 1..15
) (
    input  logic              CLK,
    input  logic              RST_N,
    rob_recovery_ctrl_if.slave bus
);

    rec_state_t       state;
    logic [CNT_W-1:0] drain_cnt;
    logic             pend_v;
    rob_idx_t         pend_idx;
    pc_t              pend_pc;
    logic             flush_q;
    pc_t              redir_pc_q;
    logic             stall_q;

    cmpl_t            alu1_c;
    cmpl_t            alu2_c;
    cmpl_t            lsu_c;
    logic             sel_v_c;
    rob_idx_t         sel_idx_c;
    pc_t              sel_pc_c;
    logic             retire_hit_c;
    logic             older_c;

    // Pack the completion ports for the age picker.
    assign alu1_c = '{valid: bus.ALU1_valid, mispred: bus.ALU1_mispred,
                      index: bus.ALU1_index, new_pc: bus.ALU1_new_PC};
    assign alu2_c = '{valid: bus.ALU2_valid, mispred: bus.ALU2_mispred,
                      index: bus.ALU2_index, new_pc: bus.ALU2_new_PC};
    assign lsu_c  = '{valid: bus.LSU_valid,  mispred: bus.LSU_mispred,
                      index: bus.LSU_index,  new_pc: bus.LSU_new_PC};

    mispred_age_select u_sel (
        .alu1       (alu1_c),
        .alu2       (alu2_c),
        .lsu        (lsu_c),
        .retire_ptr (bus.ROB_Retire_Ptr),
        .sel_V      (sel_v_c),
        .sel_index  (sel_idx_c),
        .sel_PC     (sel_pc_c)
    );

    // Either retire slot reaching the tracked entry triggers recovery.
    assign retire_hit_c = (bus.ROB_Retire1_V && (bus.ROB_Retire1_Index == pend_idx)) ||
                          (bus.ROB_Retire2_V && (bus.ROB_Retire2_Index == pend_idx));

    // A new candidate only displaces the tracked entry if strictly older.
    assign older_c = rob_age(sel_idx_c, bus.ROB_Retire_Ptr) < rob_age(pend_idx, bus.ROB_Retire_Ptr);

    // Slot 2 is younger than the mispredict retiring in slot 1, so it must not retire.
    assign bus.Squash_Retire2 = (state == PENDING) && bus.ROB_Retire1_V &&
                                (bus.ROB_Retire1_Index == pend_idx);

    assign bus.Flush          = flush_q;
    assign bus.Redirect_V     = flush_q;
    assign bus.Redirect_PC    = redir_pc_q;
    assign bus.Recovery_Stall = stall_q;
    assign bus.Pending_V      = pend_v;
    assign bus.Pending_Index  = pend_idx;

    // Recovery FSM with registered flush/redirect/stall/pending outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            pend_v     <= 1'b0;
            pend_idx   <= '0;
            pend_pc    <= '0;
            flush_q    <= 1'b0;
            redir_pc_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_v_c) begin
                        pend_v   <= 1'b1;
                        pend_idx <= sel_idx_c;
                        pend_pc  <= sel_pc_c;
                        state    <= PENDING;
                    end
                end
                PENDING: begin
                    if (retire_hit_c) begin
                        flush_q    <= 1'b1;
                        redir_pc_q <= pend_pc;
                        stall_q    <= 1'b1;
                        state      <= FLUSH;
                    end else if (sel_v_c && older_c) begin
                        pend_idx <= sel_idx_c;
                        pend_pc  <= sel_pc_c;
                    end
                end
                FLUSH: begin
                    pend_v    <= 1'b0;
                    drain_cnt <= CNT_W'(DRAIN_CYCLES);
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt <= CNT_W'(1)) begin
                        drain_cnt <= '0;
                        stall_q   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Self-checking bench for rob_recovery_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_rob_recovery_ctrl;

    localparam int unsigned IW    = 7;
    localparam int          DEPTH = 128;
    localparam int          DRAIN = 3;

    logic CLK;
    logic RST_N;
    int   tests_run;
    int   tests_failed;

    // Reference model: pending entry plus remaining recovery-stall cycles.
    bit m_pv;
    int m_pidx;
    int m_ppc;
    int m_busy;
    bit m_flush;
    int m_rpc;

    rob_recovery_ctrl_if bus ();

    rob_recovery_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int age(input int idx, input int ptr);
        return ((idx - ptr) % DEPTH + DEPTH) % DEPTH;
    endfunction

    function automatic bit exp_squash();
        return (m_busy == 0) && m_pv && bus.ROB_Retire1_V && (int'(bus.ROB_Retire1_Index) == m_pidx);
    endfunction

    task automatic model_reset();
        m_pv = 0; m_pidx = 0; m_ppc = 0; m_busy = 0; m_flush = 0; m_rpc = 0;
    endtask

    task automatic clear_inputs();
        bus.ALU1_valid = 0; bus.ALU1_mispred = 0; bus.ALU1_index = '0; bus.ALU1_new_PC = '0;
        bus.ALU2_valid = 0; bus.ALU2_mispred = 0; bus.ALU2_index = '0; bus.ALU2_new_PC = '0;
        bus.LSU_valid  = 0; bus.LSU_mispred  = 0; bus.LSU_index  = '0; bus.LSU_new_PC  = '0;
        bus.ROB_Retire1_V = 0; bus.ROB_Retire1_Index = '0;
        bus.ROB_Retire2_V = 0; bus.ROB_Retire2_Index = '0;
    endtask

    task automatic set_ptr(input int p);
        bus.ROB_Retire_Ptr = IW'(p);
    endtask

    task automatic drive_cmpl(input int port, input int idx, input int pc);
        case (port)
            0: begin bus.ALU1_valid = 1; bus.ALU1_mispred = 1; bus.ALU1_index = IW'(idx); bus.ALU1_new_PC = 16'(pc); end
            1: begin bus.ALU2_valid = 1; bus.ALU2_mispred = 1; bus.ALU2_index = IW'(idx); bus.ALU2_new_PC = 16'(pc); end
            default: begin bus.LSU_valid = 1; bus.LSU_mispred = 1; bus.LSU_index = IW'(idx); bus.LSU_new_PC = 16'(pc); end
        endcase
    endtask

    task automatic retire(input int slot, input int idx);
        if (slot == 1) begin bus.ROB_Retire1_V = 1; bus.ROB_Retire1_Index = IW'(idx); end
        else           begin bus.ROB_Retire2_V = 1; bus.ROB_Retire2_Index = IW'(idx); end
    endtask

    // Advance one clock edge and apply the recovery rules to the model.
    task automatic step();
        int q_idx[$];
        int q_pc[$];
        int ptr;
        bit hit;
        int best;
        ptr = int'(bus.ROB_Retire_Ptr);
        if (bus.ALU1_valid && bus.ALU1_mispred) begin q_idx.push_back(int'(bus.ALU1_index)); q_pc.push_back(int'(bus.ALU1_new_PC)); end
        if (bus.ALU2_valid && bus.ALU2_mispred) begin q_idx.push_back(int'(bus.ALU2_index)); q_pc.push_back(int'(bus.ALU2_new_PC)); end
        if (bus.LSU_valid  && bus.LSU_mispred)  begin q_idx.push_back(int'(bus.LSU_index));  q_pc.push_back(int'(bus.LSU_new_PC));  end
        hit = m_pv && ((bus.ROB_Retire1_V && int'(bus.ROB_Retire1_Index) == m_pidx) ||
                       (bus.ROB_Retire2_V && int'(bus.ROB_Retire2_Index) == m_pidx));
        @(posedge CLK);
        if (!RST_N) begin
            model_reset();
        end else if (m_busy > 0) begin
            if (m_busy == 1 + DRAIN) begin m_pv = 0; m_flush = 0; end
            m_busy--;
        end else if (hit) begin
            m_busy = 1 + DRAIN; m_flush = 1; m_rpc = m_ppc;
        end else if (q_idx.size() > 0) begin
            best = 0;
            foreach (q_idx[i]) if (age(q_idx[i], ptr) < age(q_idx[best], ptr)) best = i;
            if (!m_pv || age(q_idx[best], ptr) < age(m_pidx, ptr)) begin
                m_pv = 1; m_pidx = q_idx[best]; m_ppc = q_pc[best];
            end
        end
        #1;
    endtask

    task automatic run_idle(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic test_reset();
        RST_N = 0; clear_inputs(); set_ptr(0); model_reset();
        repeat (2) @(posedge CLK);
        #1;
        tests_run++; if (bus.Flush !== 1'b0)          begin tests_failed++; $display("FAIL reset_flush got %b want 0", bus.Flush); end
        tests_run++; if (bus.Redirect_V !== 1'b0)     begin tests_failed++; $display("FAIL reset_redirect_v got %b want 0", bus.Redirect_V); end
        tests_run++; if (bus.Redirect_PC !== 16'h0)   begin tests_failed++; $display("FAIL reset_redirect_pc got %h want 0", bus.Redirect_PC); end
        tests_run++; if (bus.Recovery_Stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", bus.Recovery_Stall); end
        tests_run++; if (bus.Squash_Retire2 !== 1'b0) begin tests_failed++; $display("FAIL reset_squash got %b want 0", bus.Squash_Retire2); end
        tests_run++; if (bus.Pending_V !== 1'b0)      begin tests_failed++; $display("FAIL reset_pending_v got %b want 0", bus.Pending_V); end
        tests_run++; if (bus.Pending_Index !== 7'd0)  begin tests_failed++; $display("FAIL reset_pending_index got %0d want 0", bus.Pending_Index); end
        RST_N = 1;
    endtask

    task automatic test_single_mispred();
        set_ptr(0); clear_inputs();
        drive_cmpl(0, 5, 'h1234);
        step(); clear_inputs();
        tests_run++; if (bus.Pending_V !== 1'b1 || bus.Pending_Index !== 7'd5) begin tests_failed++; $display("FAIL single_capture got v=%b idx=%0d want v=1 idx=5", bus.Pending_V, bus.Pending_Index); end
        run_idle(3);
        tests_run++; if (bus.Flush !== 1'b0 || bus.Pending_V !== 1'b1) begin tests_failed++; $display("FAIL single_hold got flush=%b v=%b want 0/1", bus.Flush, bus.Pending_V); end
        retire(1, 5);
        step(); clear_inputs();
        tests_run++; if (bus.Flush !== 1'b1 || bus.Redirect_V !== 1'b1) begin tests_failed++; $display("FAIL single_flush got flush=%b rv=%b want 1/1", bus.Flush, bus.Redirect_V); end
        tests_run++; if (bus.Redirect_PC !== 16'h1234) begin tests_failed++; $display("FAIL single_pc got %h want 1234", bus.Redirect_PC); end
        tests_run++; if (bus.Recovery_Stall !== 1'b1) begin tests_failed++; $display("FAIL single_stall0 got %b want 1", bus.Recovery_Stall); end
        for (int k = 1; k <= DRAIN; k++) begin
            step();
            tests_run++; if (bus.Flush !== 1'b0 || bus.Redirect_V !== 1'b0 || bus.Recovery_Stall !== 1'b1) begin tests_failed++; $display("FAIL single_drain%0d got flush=%b rv=%b stall=%b want 0/0/1", k, bus.Flush, bus.Redirect_V, bus.Recovery_Stall); end
        end
        step();
        tests_run++; if (bus.Recovery_Stall !== 1'b0 || bus.Pending_V !== 1'b0) begin tests_failed++; $display("FAIL single_end got stall=%b v=%b want 0/0", bus.Recovery_Stall, bus.Pending_V); end
    endtask

    task automatic test_oldest_wrap();
        set_ptr(120); clear_inputs();
        drive_cmpl(1, 2, 'h0002); drive_cmpl(2, 125, 'h0125);
        step(); clear_inputs();
        tests_run++; if (bus.Pending_Index !== 7'd125) begin tests_failed++; $display("FAIL wrap_first got %0d want 125", bus.Pending_Index); end
        drive_cmpl(0, 122, 'h0122);
        step(); clear_inputs();
        tests_run++; if (bus.Pending_Index !== 7'd122) begin tests_failed++; $display("FAIL wrap_older got %0d want 122", bus.Pending_Index); end
        drive_cmpl(1, 126, 'h0126);
        step(); clear_inputs();
        tests_run++; if (bus.Pending_Index !== 7'd122) begin tests_failed++; $display("FAIL wrap_younger got %0d want 122", bus.Pending_Index); end
        retire(2, 122);
        step(); clear_inputs();
        tests_run++; if (bus.Flush !== 1'b1 || bus.Redirect_PC !== 16'h0122) begin tests_failed++; $display("FAIL wrap_flush got flush=%b pc=%h want 1/0122", bus.Flush, bus.Redirect_PC); end
        run_idle(DRAIN + 1);
        // Equal index on ALU2 and LSU: ALU2 wins.
        set_ptr(0);
        drive_cmpl(2, 9, 'hBBBB); drive_cmpl(1, 9, 'hAAAA);
        step(); clear_inputs();
        retire(1, 9);
        step(); clear_inputs();
        tests_run++; if (bus.Redirect_PC !== 16'hAAAA) begin tests_failed++; $display("FAIL tie_priority got %h want AAAA", bus.Redirect_PC); end
        run_idle(DRAIN + 1);
    endtask

    task automatic test_squash();
        set_ptr(30); clear_inputs();
        drive_cmpl(0, 40, 'h4040);
        step(); clear_inputs();
        retire(1, 40); retire(2, 41);
        #1;
        tests_run++; if (bus.Squash_Retire2 !== 1'b1) begin tests_failed++; $display("FAIL squash_slot1 got %b want 1", bus.Squash_Retire2); end
        step(); clear_inputs();
        tests_run++; if (bus.Flush !== 1'b1) begin tests_failed++; $display("FAIL squash_flush1 got %b want 1", bus.Flush); end
        run_idle(DRAIN + 1);
        drive_cmpl(1, 40, 'h0440);
        step(); clear_inputs();
        retire(1, 39); retire(2, 40);
        #1;
        tests_run++; if (bus.Squash_Retire2 !== 1'b0) begin tests_failed++; $display("FAIL squash_slot2 got %b want 0", bus.Squash_Retire2); end
        step(); clear_inputs();
        tests_run++; if (bus.Flush !== 1'b1 || bus.Redirect_PC !== 16'h0440) begin tests_failed++; $display("FAIL squash_flush2 got flush=%b pc=%h want 1/0440", bus.Flush, bus.Redirect_PC); end
        run_idle(DRAIN + 1);
    endtask

    task automatic test_wrong_path();
        set_ptr(0); clear_inputs();
        drive_cmpl(2, 20, 'h2020);
        step(); clear_inputs();
        retire(1, 20);
        step(); clear_inputs();
        for (int k = 0; k < DRAIN; k++) begin
            drive_cmpl(2, 50, 'h5050);
            step(); clear_inputs();
        end
        step();
        tests_run++; if (bus.Pending_V !== 1'b0 || bus.Recovery_Stall !== 1'b0) begin tests_failed++; $display("FAIL wrongpath_idle got v=%b stall=%b want 0/0", bus.Pending_V, bus.Recovery_Stall); end
        step();
        tests_run++; if (bus.Pending_V !== 1'b0) begin tests_failed++; $display("FAIL wrongpath_nocap got %b want 0", bus.Pending_V); end
    endtask

    task automatic test_reset_mid_drain();
        set_ptr(0); clear_inputs();
        drive_cmpl(0, 60, 'h6060);
        step(); clear_inputs();
        retire(1, 60);
        step(); clear_inputs();
        step(); step();
        tests_run++; if (bus.Recovery_Stall !== 1'b1) begin tests_failed++; $display("FAIL middrain_pre got stall=%b want 1", bus.Recovery_Stall); end
        RST_N = 0; model_reset();
        #1;
        tests_run++; if ({bus.Flush, bus.Redirect_V, bus.Recovery_Stall, bus.Pending_V, bus.Squash_Retire2} !== 5'b0) begin tests_failed++; $display("FAIL middrain_outs got %b want 00000", {bus.Flush, bus.Redirect_V, bus.Recovery_Stall, bus.Pending_V, bus.Squash_Retire2}); end
        tests_run++; if (bus.Redirect_PC !== 16'h0 || bus.Pending_Index !== 7'd0) begin tests_failed++; $display("FAIL middrain_regs got pc=%h idx=%0d want 0/0", bus.Redirect_PC, bus.Pending_Index); end
        step(); step();
        RST_N = 1;
        for (int k = 0; k < DRAIN + 2; k++) begin
            step();
            tests_run++; if (bus.Flush !== 1'b0 || bus.Recovery_Stall !== 1'b0 || bus.Pending_V !== 1'b0) begin tests_failed++; $display("FAIL middrain_after%0d got flush=%b stall=%b v=%b want 0/0/0", k, bus.Flush, bus.Recovery_Stall, bus.Pending_V); end
        end
    endtask

    task automatic test_race();
        set_ptr(0); clear_inputs();
        drive_cmpl(0, 10, 'h1010);
        step(); clear_inputs();
        retire(1, 10); drive_cmpl(0, 12, 'h1212);
        step(); clear_inputs();
        tests_run++; if (bus.Flush !== 1'b1 || bus.Redirect_PC !== 16'h1010) begin tests_failed++; $display("FAIL race_flush got flush=%b pc=%h want 1/1010", bus.Flush, bus.Redirect_PC); end
        run_idle(DRAIN + 1);
        tests_run++; if (bus.Pending_V !== 1'b0) begin tests_failed++; $display("FAIL race_nocap got %b want 0", bus.Pending_V); end
    endtask

    task automatic test_back_to_back();
        set_ptr(0); clear_inputs();
        drive_cmpl(1, 7, 'h0707);
        step(); clear_inputs();
        retire(2, 7);
        step(); clear_inputs();
        run_idle(DRAIN + 1);
        tests_run++; if (bus.Recovery_Stall !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got stall=%b want 0", bus.Recovery_Stall); end
        drive_cmpl(2, 8, 'h0808);
        step(); clear_inputs();
        tests_run++; if (bus.Pending_V !== 1'b1 || bus.Pending_Index !== 7'd8) begin tests_failed++; $display("FAIL b2b_capture got v=%b idx=%0d want 1/8", bus.Pending_V, bus.Pending_Index); end
        retire(1, 8);
        step(); clear_inputs();
        tests_run++; if (bus.Redirect_PC !== 16'h0808 || bus.Flush !== 1'b1) begin tests_failed++; $display("FAIL b2b_flush got flush=%b pc=%h want 1/0808", bus.Flush, bus.Redirect_PC); end
        run_idle(DRAIN + 1);
    endtask

    task automatic test_random();
        bit sq;
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            if ($urandom_range(0, 49) == 0) set_ptr(int'($urandom_range(0, DEPTH - 1)));
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 5) == 0) drive_cmpl(p, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 65535)));
            end
            if ($urandom_range(0, 7) == 0) bus.ALU2_mispred = 0;
            if (m_pv && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin retire(1, m_pidx); retire(2, (m_pidx + 1) % DEPTH); end
                else                           begin retire(1, (m_pidx + DEPTH - 1) % DEPTH); retire(2, m_pidx); end
            end else if ($urandom_range(0, 2) == 0) begin
                retire(1, int'($urandom_range(0, DEPTH - 1)));
                if ($urandom_range(0, 1) == 0) retire(2, int'($urandom_range(0, DEPTH - 1)));
            end
            #1;
            sq = exp_squash();
            tests_run++; if (bus.Squash_Retire2 !== sq) begin tests_failed++; $display("FAIL rnd_squash c=%0d got %b want %b", c, bus.Squash_Retire2, sq); end
            step();
            tests_run++; if (bus.Flush !== m_flush || bus.Redirect_V !== m_flush) begin tests_failed++; $display("FAIL rnd_flush c=%0d got flush=%b rv=%b want %b", c, bus.Flush, bus.Redirect_V, m_flush); end
            tests_run++; if (bus.Recovery_Stall !== (m_busy > 0)) begin tests_failed++; $display("FAIL rnd_stall c=%0d got %b want %b", c, bus.Recovery_Stall, (m_busy > 0)); end
            tests_run++; if (bus.Pending_V !== m_pv) begin tests_failed++; $display("FAIL rnd_pending_v c=%0d got %b want %b", c, bus.Pending_V, m_pv); end
            if (m_pv) begin
                tests_run++; if (int'(bus.Pending_Index) != m_pidx) begin tests_failed++; $display("FAIL rnd_pending_idx c=%0d got %0d want %0d", c, bus.Pending_Index, m_pidx); end
            end
            if (m_flush) begin
                tests_run++; if (int'(bus.Redirect_PC) != m_rpc) begin tests_failed++; $display("FAIL rnd_redirect_pc c=%0d got %h want %h", c, bus.Redirect_PC, 16'(m_rpc)); end
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_mispred();
        test_oldest_wrap();
        test_squash();
        test_wrong_path();
        test_reset_mid_drain();
        test_race();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
